text_load_sequencer: RTL and testbench

Feeds the scrolling text display's serial load interface (display reset, write, din) from two independent 7-bit character sources (A, B). Serialises each accepted character into the display's 8-cycle word slot: 7 data bits, LSB first, then 1 rotate cycle. Arbitrates round-robin between A and B at message granularity and performs a whole-screen clear on request. Keeps the display's internal 3-bit slot counter aligned by owning its reset.

---
 rtl/text_load_sequencer_if.sv | 49 ++++
 rtl/text_load_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_text_load_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// text_load_sequencer_if
//   Groups the two character-source handshakes, the clear request and the
//   serial display load outputs of the text load sequencer into one bundle.
//
//   Signals
//     a_valid/a_data/a_last/a_ready : character source A handshake
//     b_valid/b_data/b_last/b_ready : character source B handshake
//     clear                         : single-cycle request to blank the buffer
//     disp_reset/disp_write/disp_din: serial load interface of the display
//     owner                         : 00 none, 01 A, 10 B, 11 clear running
//     busy                          : sequencer not idle
//     frame_done                    : one pulse per WORD_COUNT characters
//
//   Modports
//     master : the side that owns the sources (drives valid/data/last/clear)
//     slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface text_load_sequencer_if #(
   parameter int CHAR_BITS = 7
);
   logic                 a_valid;
   logic [CHAR_BITS-1:0] a_data;
   logic                 a_last;
   logic                 a_ready;
   logic                 b_valid;
   logic [CHAR_BITS-1:0] b_data;
   logic                 b_last;
   logic                 b_ready;
   logic                 clear;
   logic                 disp_reset;
   logic                 disp_write;
   logic                 disp_din;
   logic [1:0]           owner;
   logic                 busy;
   logic                 frame_done;

   modport master (
      output a_valid, a_data, a_last, b_valid, b_data, b_last, clear,
      input  a_ready, b_ready, disp_reset, disp_write, disp_din, owner, busy,
             frame_done
   );

   modport slave (
      input  a_valid, a_data, a_last, b_valid, b_data, b_last, clear,
      output a_ready, b_ready, disp_reset, disp_write, disp_din, owner, busy,
             frame_done
   );
endinterface

// File: rtl/text_load_sequencer.sv
// ---------------------------------------------------------------------------
// text_load_sequencer
//   Feeds a scrolling text display's serial load port from two independent
//   character sources. Each accepted character occupies one 8-cycle word slot
//   on the display: CHAR_BITS data bits LSB first, then one rotate cycle with
//   din low. Sources are arbitrated round-robin per message (a message is
//   locked to its source until the character flagged last), and a clear
//   request blanks the whole buffer by writing WORD_COUNT empty slots.
//   The sequencer owns the display reset so the display's internal slot
//   counter always lines up with our slot boundaries.
//
//   Ports
//     clk   : rising-edge clock shared with the display
//     reset : synchronous, active-low
//     bus   : text_load_sequencer_if.slave (sources, clear, display outputs)
// ---------------------------------------------------------------------------
module text_load_sequencer #(
   parameter int WORD_COUNT = 28,
   parameter int CHAR_BITS  = 7
) (
   input logic                   clk,
   input logic                   reset,
   text_load_sequencer_if.slave  bus
);

   localparam int SLOT_CYCLES  = CHAR_BITS + 1;
   localparam int CLEAR_CYCLES = WORD_COUNT * SLOT_CYCLES;
   localparam int CLR_W        = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam int CNT_W        = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam int IDX_W        = (CHAR_BITS > 1) ? $clog2(CHAR_BITS) : 1;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_IDLE,
      ST_SHIFT,
      ST_GAP,
      ST_CLEAR
   } state_t;

   state_t               state_q, state_d;
   logic                 hold_q, hold_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CHAR_BITS-1:0] data_q, data_d;
   logic                 src_q, src_d;
   logic                 last_q, last_d;
   logic                 lock_q, lock_d;
   logic                 last_grant_q, last_grant_d;
   logic                 clear_pend_q, clear_pend_d;
   logic [CNT_W-1:0]     char_cnt_q, char_cnt_d;
   logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
   logic                 frame_d;
   logic                 grant_a, grant_b;
   logic                 take_a, take_b;

   logic                 disp_reset_q, disp_reset_d;
   logic                 disp_write_q, disp_write_d;
   logic                 disp_din_q, disp_din_d;
   logic [1:0]           owner_q, owner_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;

   // State register. Every display-facing output is also a flop here so the
   // display sees clean registered levels; the *_d values come from the
   // output logic below, which looks at where we are going next. A low reset
   // throws away everything in flight, including a half-sent character, a
   // pending clear and the message lock. last_grant comes back as B so that
   // A wins the very first tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_HOLD;
         hold_q       <= 1'b0;
         idx_q        <= '0;
         data_q       <= '0;
         src_q        <= 1'b0;
         last_q       <= 1'b0;
         lock_q       <= 1'b0;
         last_grant_q <= 1'b1;
         clear_pend_q <= 1'b0;
         char_cnt_q   <= '0;
         clr_cnt_q    <= '0;
         disp_reset_q <= 1'b1;
         disp_write_q <= 1'b0;
         disp_din_q   <= 1'b0;
         owner_q      <= 2'b00;
         busy_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         src_q        <= src_d;
         last_q       <= last_d;
         lock_q       <= lock_d;
         last_grant_q <= last_grant_d;
         clear_pend_q <= clear_pend_d;
         char_cnt_q   <= char_cnt_d;
         clr_cnt_q    <= clr_cnt_d;
         disp_reset_q <= disp_reset_d;
         disp_write_q <= disp_write_d;
         disp_din_q   <= disp_din_d;
         owner_q      <= owner_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state logic. The grant decision is made here because it steers
   // both the transition and the ready lines. Grants only exist in IDLE
   // (clear first, then the locked owner, then round-robin) and in GAP while
   // a message is still open, where the owner may chain its next character
   // straight into the following slot. A clear seen while busy is remembered
   // and merged with any later pulse until IDLE gets to execute it. The
   // character counter advances on entry to GAP so frame_done lines up with
   // the rotate cycle of the WORD_COUNT-th character.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      idx_d        = idx_q;
      data_d       = data_q;
      src_d        = src_q;
      last_d       = last_q;
      lock_d       = lock_q;
      last_grant_d = last_grant_q;
      clear_pend_d = clear_pend_q | bus.clear;
      char_cnt_d   = char_cnt_q;
      clr_cnt_d    = clr_cnt_q;
      frame_d      = 1'b0;
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      take_a       = 1'b0;
      take_b       = 1'b0;

      case (state_q)
         ST_HOLD: begin
            if (hold_q) begin
               state_d = ST_IDLE;
            end else begin
               hold_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear_pend_q || bus.clear) begin
               state_d      = ST_CLEAR;
               clr_cnt_d    = '0;
               clear_pend_d = 1'b0;
            end else if (lock_q) begin
               grant_a = !src_q && bus.a_valid;
               grant_b = src_q && bus.b_valid;
            end else if (bus.a_valid && bus.b_valid) begin
               grant_a = last_grant_q;
               grant_b = !last_grant_q;
            end else begin
               grant_a = bus.a_valid;
               grant_b = bus.b_valid;
            end
         end
         ST_SHIFT: begin
            if (idx_q == IDX_W'(CHAR_BITS - 1)) begin
               state_d = ST_GAP;
               frame_d = (char_cnt_q == CNT_W'(WORD_COUNT - 1));
               char_cnt_d = frame_d ? '0 : char_cnt_q + 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
            if (last_q) begin
               lock_d       = 1'b0;
               last_grant_d = src_q;
            end else begin
               grant_a = !src_q;
               grant_b = src_q;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
               state_d    = ST_IDLE;
               char_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase

      // A source must never believe it handed over a character that the
      // coming reset is about to throw away.
      if (!reset) begin
         grant_a = 1'b0;
         grant_b = 1'b0;
      end

      take_a = grant_a && bus.a_valid;
      take_b = grant_b && bus.b_valid;
      if (take_a || take_b) begin
         state_d = ST_SHIFT;
         idx_d   = '0;
         src_d   = take_b;
         data_d  = take_b ? bus.b_data : bus.a_data;
         last_d  = take_b ? bus.b_last : bus.a_last;
         if (!last_d) begin
            lock_d = 1'b1;
         end
      end
   end

   // Output logic. Computes the values the output flops take at the next
   // edge from the next-state values, so each registered output describes
   // the cycle the sequencer is entering. While idle, owner keeps showing a
   // source that still holds an open message.
   always_comb begin
      disp_reset_d = (state_d == ST_HOLD);
      disp_write_d = (state_d == ST_SHIFT) || (state_d == ST_GAP) ||
                     (state_d == ST_CLEAR);
      disp_din_d   = (state_d == ST_SHIFT) ? data_d[idx_d] : 1'b0;
      busy_d       = (state_d != ST_IDLE);
      frame_done_d = frame_d;
      owner_d      = 2'b00;
      case (state_d)
         ST_CLEAR: owner_d = 2'b11;
         ST_SHIFT,
         ST_GAP:   owner_d = src_d ? 2'b10 : 2'b01;
         ST_IDLE:  owner_d = lock_d ? (src_d ? 2'b10 : 2'b01) : 2'b00;
         default:  owner_d = 2'b00;
      endcase
   end

   assign bus.a_ready    = grant_a;
   assign bus.b_ready    = grant_b;
   assign bus.disp_reset = disp_reset_q;
   assign bus.disp_write = disp_write_q;
   assign bus.disp_din   = disp_din_q;
   assign bus.owner      = owner_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_text_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_text_load_sequencer
//   Drives two character sources and the clear request, and compares every
//   DUT output each cycle with a reference model. The model keeps a queue of
//   the display slots still owed (one entry per future clock cycle): an
//   accepted character appends 7 data cycles plus a rotate cycle, a clear
//   appends WORD_COUNT*8 blank cycles, and an empty queue means idle.
// ---------------------------------------------------------------------------
module tb_text_load_sequencer;

   localparam int WORD_COUNT   = 28;
   localparam int CHAR_BITS    = 7;
   localparam int CLEAR_CYCLES = WORD_COUNT * (CHAR_BITS + 1);

   logic clk = 1'b0;
   logic reset = 1'b0;

   text_load_sequencer_if #(.CHAR_BITS(CHAR_BITS)) bus();

   text_load_sequencer #(
      .WORD_COUNT(WORD_COUNT),
      .CHAR_BITS (CHAR_BITS)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // One owed display cycle.
   typedef struct packed {
      logic       w;
      logic       d;
      logic [1:0] own;
      logic       fd;
      logic       gap;
      logic       last;
      logic       src;
      logic       hold;
   } slot_t;

   typedef struct packed {
      logic [6:0] d;
      logic       l;
   } chr_t;

   slot_t sched[$];
   slot_t cur;
   logic  cur_idle;
   logic  m_lock;
   logic  m_lsrc;
   logic  m_last_grant;
   logic  m_pend;
   int    m_cnt;

   chr_t       qa[$];
   chr_t       qb[$];
   logic       sv[2];
   logic [6:0] sd[2];
   logic       sl[2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Counts one comparison and reports it if the DUT disagrees.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: observed=%0h expected=%0h",
                  tag, cyc, observed, expected);
      end
   endtask

   task automatic popCur();
      cur_idle = (sched.size() == 0);
      if (cur_idle) cur = '0;
      else          cur = sched.pop_front();
   endtask

   // A low reset at an edge means: this cycle and the one after the first
   // high edge are both display-reset cycles.
   task automatic modelReset();
      slot_t h;
      h = '0;
      h.hold = 1'b1;
      sched.delete();
      sched.push_back(h);
      sched.push_back(h);
      m_lock       = 1'b0;
      m_lsrc       = 1'b0;
      m_last_grant = 1'b1;
      m_pend       = 1'b0;
      m_cnt        = 0;
   endtask

   task automatic pushChar(input logic src, input logic [6:0] data,
                           input logic last);
      slot_t s;
      for (int k = 0; k < 7; k++) begin
         s     = '0;
         s.w   = 1'b1;
         s.d   = data[k];
         s.own = src ? 2'b10 : 2'b01;
         s.src = src;
         sched.push_back(s);
      end
      s      = '0;
      s.w    = 1'b1;
      s.own  = src ? 2'b10 : 2'b01;
      s.gap  = 1'b1;
      s.last = last;
      s.src  = src;
      s.fd   = (m_cnt == WORD_COUNT - 1);
      m_cnt  = (m_cnt + 1) % WORD_COUNT;
      sched.push_back(s);
      if (!last) begin
         m_lock = 1'b1;
         m_lsrc = src;
      end
   endtask

   task automatic pushClear();
      slot_t s;
      s     = '0;
      s.w   = 1'b1;
      s.own = 2'b11;
      for (int k = 0; k < CLEAR_CYCLES; k++) sched.push_back(s);
      m_cnt = 0;
   endtask

   // Which source the model says is ready this cycle.
   task automatic expectReady(output logic ra, output logic rb);
      ra = 1'b0;
      rb = 1'b0;
      if (reset) begin
         if (cur_idle) begin
            if (!(bus.clear || m_pend)) begin
               if (m_lock) begin
                  ra = !m_lsrc && sv[0];
                  rb = m_lsrc && sv[1];
               end else if (sv[0] && sv[1]) begin
                  ra = (m_last_grant == 1'b1);
                  rb = (m_last_grant == 1'b0);
               end else begin
                  ra = sv[0];
                  rb = sv[1];
               end
            end
         end else if (cur.gap && !cur.last) begin
            ra = !cur.src;
            rb = cur.src;
         end
      end
   endtask

   task automatic advanceModel(input logic ha, input logic hb);
      if (!reset) begin
         modelReset();
      end else begin
         if (!cur_idle && cur.gap && cur.last) begin
            m_lock       = 1'b0;
            m_last_grant = cur.src;
         end
         if (cur_idle && (bus.clear || m_pend)) begin
            m_pend = 1'b0;
            pushClear();
         end else begin
            if (bus.clear) m_pend = 1'b1;
            if (ha)      pushChar(1'b0, sd[0], sl[0]);
            else if (hb) pushChar(1'b1, sd[1], sl[1]);
         end
         if (ha) sv[0] = 1'b0;
         if (hb) sv[1] = 1'b0;
      end
      popCur();
   endtask

   // Sources hold a character until it is accepted; queued directed
   // characters take precedence over random ones.
   task automatic applyStimulus(input logic rst, input logic clr, input int pa,
                                input int pb, input int plast);
      chr_t c;
      reset = rst;
      for (int i = 0; i < 2; i++) begin
         if (!sv[i]) begin
            if (i == 0 && qa.size() > 0) begin
               c = qa.pop_front();
               sd[i] = c.d; sl[i] = c.l; sv[i] = 1'b1;
            end else if (i == 1 && qb.size() > 0) begin
               c = qb.pop_front();
               sd[i] = c.d; sl[i] = c.l; sv[i] = 1'b1;
            end else if ($urandom_range(99, 0) < ((i == 0) ? pa : pb)) begin
               sd[i] = 7'($urandom);
               sl[i] = ($urandom_range(99, 0) < plast);
               sv[i] = 1'b1;
            end
         end
      end
      bus.a_valid = sv[0];
      bus.a_data  = sd[0];
      bus.a_last  = sl[0];
      bus.b_valid = sv[1];
      bus.b_data  = sd[1];
      bus.b_last  = sl[1];
      bus.clear   = clr;
   endtask

   task automatic checkAll(input logic ra, input logic rb);
      logic [1:0] own;
      if (cur_idle) own = m_lock ? (m_lsrc ? 2'b10 : 2'b01) : 2'b00;
      else          own = cur.own;
      checkOutput("disp_reset", 8'(bus.disp_reset), 8'(!cur_idle && cur.hold));
      checkOutput("disp_write", 8'(bus.disp_write), 8'(!cur_idle && cur.w));
      checkOutput("disp_din",   8'(bus.disp_din),   8'(!cur_idle && cur.d));
      checkOutput("owner",      8'(bus.owner),      8'(own));
      checkOutput("busy",       8'(bus.busy),       8'(!cur_idle));
      checkOutput("frame_done", 8'(bus.frame_done), 8'(!cur_idle && cur.fd));
      checkOutput("a_ready",    8'(bus.a_ready),    8'(ra));
      checkOutput("b_ready",    8'(bus.b_ready),    8'(rb));
   endtask

   // Runs ncyc cycles. Probabilities pa/pb/plast are percent, pclr/prst are
   // per ten thousand; clr_at and rst_at force a clear pulse or a reset
   // window at a given cycle of the phase (-1 for none).
   task automatic runPhase(input int ncyc, input int pa, input int pb,
                           input int plast, input int pclr, input int clr_at,
                           input int rst_at, input int rst_len, input int prst);
      logic r, c, ra, rb;
      for (int i = 0; i < ncyc; i++) begin
         r = !((i >= rst_at && i < rst_at + rst_len) ||
               ($urandom_range(9999, 0) < prst));
         c = (i == clr_at) || ($urandom_range(9999, 0) < pclr);
         applyStimulus(r, c, pa, pb, plast);
         #1;
         expectReady(ra, rb);
         checkAll(ra, rb);
         advanceModel(ra && sv[0], rb && sv[1]);
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      sv[0] = 1'b0; sv[1] = 1'b0;
      sd[0] = '0;   sd[1] = '0;
      sl[0] = 1'b0; sl[1] = 1'b0;
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
      modelReset();
      popCur();
      @(posedge clk);
      #1;

      // Reset held low for three edges in total, then released and quiet.
      runPhase(8, 0, 0, 0, 0, -1, 0, 2, 0);

      // Single character 0x41 from A, last set.
      qa.push_back('{d: 7'h41, l: 1'b1});
      runPhase(14, 0, 0, 0, 0, -1, -1, 0, 0);

      // Three back-to-back characters from A with valid held.
      qa.push_back('{d: 7'h12, l: 1'b0});
      qa.push_back('{d: 7'h55, l: 1'b0});
      qa.push_back('{d: 7'h7f, l: 1'b1});
      runPhase(32, 0, 0, 0, 0, -1, -1, 0, 0);

      // Tie and lock: A's two-char message blocks B, then a second tie.
      qa.push_back('{d: 7'h21, l: 1'b0});
      qa.push_back('{d: 7'h22, l: 1'b1});
      qb.push_back('{d: 7'h31, l: 1'b1});
      qa.push_back('{d: 7'h23, l: 1'b1});
      qb.push_back('{d: 7'h32, l: 1'b1});
      runPhase(70, 0, 0, 0, 0, -1, -1, 0, 0);

      // Clear pulsed during an A character, then 28+ characters.
      qa.push_back('{d: 7'h10, l: 1'b0});
      qa.push_back('{d: 7'h11, l: 1'b1});
      runPhase(260, 0, 0, 0, 0, 3, -1, 0, 0);
      runPhase(600, 60, 60, 50, 0, -1, -1, 0, 0);

      // Reset in the middle of a character.
      runPhase(30, 0, 0, 0, 0, -1, -1, 0, 0);
      qa.push_back('{d: 7'h5a, l: 1'b1});
      runPhase(30, 0, 0, 0, 0, -1, 4, 1, 0);

      // Random traffic with occasional clears, then with resets too.
      runPhase(2500, 30, 30, 40, 15, -1, -1, 0, 0);
      runPhase(3000, 40, 40, 50, 10, -1, -1, 0, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
